bulls_cows_solver: RTL

//  Machine-side guesser for the 1A2B game, the reverse of the judge: the player holds a 4-digit

---
 rtl/bulls_cows_solver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bulls_cows_solver.sv
// Guessing side of the 1A2B game: proposes BCD guesses and searches for a candidate consistent with all scored history.
// Optional build macro SOLVER_DISTINCT_DIGITS_EN skips candidates with repeated digits.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CHECK   | testing cand against one history entry per cycle
// PRESENT | guess shown, waiting for the player's score
// SOLVED  | player scored 4A, last guess held
// FAIL    | search exhausted or history full, guess forced to 0
module bulls_cows_solver #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             fb_valid,
  input  logic [2:0]       fb_a,
  input  logic [2:0]       fb_b,
  output logic [15:0]      guess,
  output logic             guess_valid,
  output logic             busy,
  output logic             solved,
  output logic             fail,
  output logic [TRY_W-1:0] tries
);

  localparam int IDX_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PRESENT, S_SOLVED, S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cand_q, cand_d;
  logic [15:0]      guess_q, guess_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TRY_W-1:0] cnt_q, cnt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             hist_we;

  logic [15:0] hist_g [MAX_TRIES];
  logic [2:0]  hist_a [MAX_TRIES];
  logic [2:0]  hist_b [MAX_TRIES];

  function automatic logic [5:0] score(input logic [15:0] g, input logic [15:0] c);
    logic [2:0] a;
    logic [2:0] b;
    logic       hit;
    a = 3'd0;
    b = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[4*i +: 4] == c[4*i +: 4]) a = a + 3'd1;
      hit = 1'b0;
      for (int j = 0; j < 4; j++)
        if (j != i && g[4*i +: 4] == c[4*j +: 4]) hit = 1'b1;
      if (hit) b = b + 3'd1;
    end
    return {a, b};
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        cy;
    r  = v;
    cy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          cy = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic has_repeat(input logic [15:0] v);
    logic rep;
    rep = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) rep = 1'b1;
    return rep;
  endfunction

  logic skip;
`ifdef SOLVER_DISTINCT_DIGITS_EN
  assign skip = has_repeat(cand_q);
`else
  assign skip = 1'b0;
`endif

  logic reject;
  logic idx_last;
  assign reject   = skip || ((cnt_q != '0) &&
                    (score(hist_g[idx_q], cand_q) != {hist_a[idx_q], hist_b[idx_q]}));
  assign idx_last = (cnt_q == '0) || (idx_q == IDX_W'(cnt_q - TRY_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      guess_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      guess_q <= guess_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
    end
  end

  // History has no reset; cnt_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (hist_we && !rst) begin
      hist_g[IDX_W'(cnt_q)] <= guess_q;
      hist_a[IDX_W'(cnt_q)] <= fb_a;
      hist_b[IDX_W'(cnt_q)] <= fb_b;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    guess_d = guess_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    hist_we = 1'b0;
    case (state_q)
      S_IDLE, S_SOLVED, S_FAIL: begin
        if (start) begin
          cnt_d   = '0;
          tries_d = '0;
          cand_d  = '0;
          idx_d   = '0;
          guess_d = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          if (cand_q == 16'h9999) begin
            guess_d = '0;
            state_d = S_FAIL;
          end else begin
            cand_d = bcd_inc(cand_q);
            idx_d  = '0;
          end
        end else if (idx_last) begin
          guess_d = cand_q;
          state_d = S_PRESENT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_PRESENT: begin
        if (fb_valid) begin
          tries_d = tries_q + TRY_W'(1);
          if (fb_a == 3'd4) begin
            state_d = S_SOLVED;
          end else begin
            hist_we = 1'b1;
            cnt_d   = cnt_q + TRY_W'(1);
            if (cnt_q + TRY_W'(1) == TRY_W'(MAX_TRIES) || guess_q == 16'h9999) begin
              guess_d = '0;
              state_d = S_FAIL;
            end else begin
              cand_d  = bcd_inc(guess_q);
              idx_d   = '0;
              state_d = S_CHECK;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign guess       = guess_q;
  assign tries       = tries_q;
  assign guess_valid = (state_q == S_PRESENT);
  assign busy        = (state_q == S_CHECK);
  assign solved      = (state_q == S_SOLVED);
  assign fail        = (state_q == S_FAIL);

endmodule
